// File: rtl/jtframe_sddac.sv
// jtframe_sddac: multi-channel first-order sigma-delta audio DAC with a
// soft mute. A shared gain (0..128) ramps linearly, so the output starts up
// and shuts down without clicks.
module jtframe_sddac #(
  parameter int   CHANNELS   = 2,
  parameter int   INW        = 16,
  parameter logic SIGNED_SND = 1'b1,
  parameter int   CEN_DIV    = 4,
  parameter int   RAMP_DIV   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS*INW-1:0] snd_in,
  input  logic                    mute,
  output logic [CHANNELS-1:0]     dac_out,
  output logic                    muted,
  output logic                    ramp_busy
);

  localparam int CW = $clog2(CEN_DIV);
  localparam int SW = $clog2(RAMP_DIV + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CEN_DIV - 1);
  localparam logic [SW-1:0]  SC_LAST  = SW'(RAMP_DIV - 1);
  localparam logic [INW-1:0] MID      = {1'b1, {(INW-1){1'b0}}};
  localparam logic [INW:0]   MID1     = {1'b0, MID};

  localparam logic [1:0] ST_MUTED = 2'd0;
  localparam logic [1:0] ST_UP    = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_DOWN  = 2'd3;

  logic [CW-1:0] cnt;
  logic [SW-1:0] sc;
  logic [1:0]    st;
  logic [7:0]    g;
  logic          cen;
  logic          step;

  assign cen       = (cnt == CNT_LAST);
  assign step      = cen && (sc == SC_LAST);
  assign muted     = (g == 8'd0);
  assign ramp_busy = (g != 8'd0) && (g != 8'd128);

  // Modulator clock enable divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (cen) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  // Gain step pacing: counts every cen, never cleared on direction change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      sc <= '0;
    else if (cen) sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
  end

  // Soft-mute gain state machine; direction follows mute on every clock.
  // A reversal at an end stop (g=0 or g=128) lands directly in the matching
  // rest state so the ramp can never wrap past its limits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_MUTED;
      g  <= '0;
    end else begin
      case (st)
        ST_MUTED: if (!mute) st <= ST_UP;
        ST_PLAY:  if (mute)  st <= ST_DOWN;
        ST_UP: begin
          if (step) g <= g + 8'd1;
          if (step && g == 8'd127)  st <= ST_PLAY;
          else if (mute && g == 8'd0 && !step) st <= ST_MUTED;
          else if (mute)            st <= ST_DOWN;
        end
        default: begin
          if (step) g <= g - 8'd1;
          if (step && g == 8'd1)    st <= ST_MUTED;
          else if (!mute && g == 8'd128 && !step) st <= ST_PLAY;
          else if (!mute)           st <= ST_UP;
        end
      endcase
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [INW-1:0]          snd, u, s, s_reg;
    logic signed [INW:0]     d;
    logic signed [INW+8:0]   dx, gx, p;
    logic [INW:0]            acc;
    logic                    unused_p;

    // Scale the midscale-relative sample by g/128
    assign snd      = snd_in[n*INW +: INW];
    assign u        = {snd[INW-1] ^ SIGNED_SND, snd[INW-2:0]};
    assign d        = $signed({1'b0, u} - MID1);
    assign dx       = {{8{d[INW]}}, d};
    assign gx       = {{(INW+1){1'b0}}, g};
    assign p        = dx * gx;
    assign s        = MID + p[INW+6:7];
    assign unused_p = ^{p[INW+8:INW+7], p[6:0]};

    // Two-stage pipeline: sample register, then first-order accumulator
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_reg <= MID;
        acc   <= '0;
      end else if (cen) begin
        s_reg <= s;
        acc   <= {1'b0, acc[INW-1:0]} + {1'b0, s_reg};
      end
    end

    assign dac_out[n] = acc[INW];
  end

endmodule

// File: doc/jtframe_sddac.md
JTFRAME_SDDAC -- requirements
Module: jtframe_sddac

Interface
REQ-001 CHANNELS, default 2, number of independent audio channels (1..4).
REQ-002 INW, default 16, input sample width per channel (8..24).
REQ-003 SIGNED_SND, default 1'b1, 1 = samples are two's complement; 0 = offset binary.
REQ-004 CEN_DIV, default 4, clock cycles per modulator update (2..16).
REQ-005 RAMP_DIV, default 256, modulator updates per gain step (1..4096).
REQ-006 clk  input  1  modulator clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 snd_in  input  CHANNELS*INW  packed samples; channel n at bits [n*INW +: INW].
REQ-009 mute  input  1  request a soft mute; level-sensitive.
REQ-010 dac_out  output  CHANNELS  1-bit sigma-delta stream per channel.
REQ-011 muted  output  1  high while gain = 0.
REQ-012 ramp_busy  output  1  high while gain is strictly between 0 and 128.

Function
REQ-013 Clock enable: counter cnt runs 0..CEN_DIV-1 and wraps; cen is high in the cycle where cnt = CEN_DIV-1. The first cen occurs CEN_DIV cycles after rst release.
REQ-014 Conversion: u = {snd[INW-1]^SIGNED_SND, snd[INW-2:0]}, unsigned INW bits, midscale M = 2^(INW-1).
REQ-015 Gain g is a shared 8-bit register, range 0..128.
REQ-016 Scaling: d = u - M (signed, INW+1 bits); p = d*g (signed, INW+9 bits); s = M + (p >>> 7) (arithmetic shift).
REQ-017 With g = 128, s = u exactly. With g = 0, s = M.
REQ-018 Pipeline stage 1: on each cen, s is computed from the current snd_in and g and registered per channel.
REQ-019 Pipeline stage 2: on each cen, acc[INW:0] <= {1'b0, acc[INW-1:0]} + s_reg; dac_out = acc[INW] (registered). A sample captured at cen k affects dac_out after cen k+1.
REQ-020 Gain state machine states: MUTED (g=0), UP, PLAY (g=128), DOWN.
REQ-021 Step counter sc counts cen pulses 0..RAMP_DIV-1 and wraps. A step occurs on a cen where sc = RAMP_DIV-1.
REQ-022 Transitions: MUTED->UP when mute=0; PLAY->DOWN when mute=1; UP->DOWN when mute=1; DOWN->UP when mute=0. Direction changes take effect immediately, and sc is not cleared.
REQ-023 On a step, UP increments g and enters PLAY on reaching 128; DOWN decrements g and enters MUTED on reaching 0; no step occurs in MUTED or PLAY.
REQ-024 A full 0->128 ramp takes 128*RAMP_DIV*CEN_DIV clock cycles.
REQ-025 muted and ramp_busy are decoded combinationally from g.
REQ-026 snd_in changes between cen pulses are ignored; only the value present at cen is sampled.

Reset
REQ-027 Reset values: cnt=0, sc=0, g=0, state MUTED, all s_reg = M, all acc = 0, dac_out = 0, muted = 1, ramp_busy = 0.
REQ-028 After reset release with mute=0, the block soft-starts by ramping up from 0.
REQ-029 rst asserted mid-ramp or mid-stream returns every register to its REQ-027 value within the same cycle; no partial state survives.

Verification
REQ-030 INW=16, SIGNED_SND=1, mute=0, snd=16'h0000, after ramp complete -> dac_out ones density exactly 50% over any 2 consecutive cen; acc toggles between 0x0000 and 0x8000 phases.
REQ-031 SIGNED_SND=1, snd=16'h7FFF with g=128 -> s=0xFFFF, ones density 65535/65536; snd=16'h8000 -> s=0, dac_out held at 0.
REQ-032 SIGNED_SND=0, snd=16'h4000 -> 25% ones density, exactly 1 in every 4 cen.
REQ-033 CEN_DIV=4, RAMP_DIV=2, mute=0 from reset -> g=128 and ramp_busy falls at clock cycle 4 + 128*8 - 4; muted falls after the first step.
REQ-034 Mute raised when g=64 in UP -> next step gives g=63; g reaches 0 and muted=1 after 63 more steps; dac_out density settles to 50%.
REQ-035 CHANNELS=2, channel 0 = 16'h0000, channel 1 = 16'h8000 (signed) -> channel 0 gives 50% density and channel 1 gives 0%, independently; rst pulsed mid-ramp -> g=0 and dac_out=2'b00 immediately.
